bar_frame_loader: RTL and testbench

- Sequences reads from the VGA bar FIFO (32-bit words, 4 bars per word, non-show-ahead, single clock).
- On a start request, fetches exactly one frame of NUM_BARS bar heights into a shadow buffer.
- Transfers the shadow buffer to the display register only at a frame boundary, so the VGA controller never shows a torn, half-updated bar set.
- Sits between the Nios II "data back" handshake, the VGA FIFO read side and the VGA controller height input.

---
 rtl/bar_frame_loader_if.sv | 27 ++
 rtl/bar_frame_loader.sv | 148 ++++++++++++++
 tb/tb_bar_frame_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bar_frame_loader_if.sv
// Bundle of the handshake and data signals between the Nios data-back PIO,
// the VGA bar FIFO read port, the VGA controller and bar_frame_loader.
// The loader uses the slave modport; the driving side uses master.
interface bar_frame_loader_if #(
    parameter int NUM_BARS = 20,
    parameter int BAR_W    = 6
);
    logic                        start;
    logic                        frame_start;
    logic [31:0]                 fifo_q;
    logic                        fifo_empty;
    logic                        fifo_rdreq;
    logic [NUM_BARS*BAR_W-1:0]   height_out;
    logic                        frame_valid;
    logic                        busy;
    logic                        underflow_err;

    modport slave (
        input  start, frame_start, fifo_q, fifo_empty,
        output fifo_rdreq, height_out, frame_valid, busy, underflow_err
    );

    modport master (
        output start, frame_start, fifo_q, fifo_empty,
        input  fifo_rdreq, height_out, frame_valid, busy, underflow_err
    );
endinterface

// File: rtl/bar_frame_loader.sv
// bar_frame_loader: on a start request reads one frame of NUM_BARS bar
// heights (4 bars per 32-bit FIFO word) into a shadow buffer, then copies
// the shadow to height_out only on a vertical-blank frame_start, so the
// display never shows a half-updated frame.
// Optional build macro: BAR_SATURATE_EN -- clamp lane values that do not
// fit in BAR_W bits to the maximum height instead of truncating them.
module bar_frame_loader #(
    parameter int NUM_BARS    = 20,
    parameter int BAR_W       = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    bar_frame_loader_if.slave bus
);
    localparam int WORDS    = NUM_BARS / 4;
    localparam int CNT_W    = $clog2(WORDS + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int H_W      = NUM_BARS * BAR_W;
    localparam int WORD_H_W = 4 * BAR_W;
    localparam int MAX_H    = (1 << BAR_W) - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_PENDING = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    capt_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                rd_d1;
    logic                pending_start;
    logic [H_W-1:0]      shadow;
    logic [WORD_H_W-1:0] word_heights;
    logic                words_left;
    logic                tmo_hit;
    logic                last_capt;

    // Map one 8-bit FIFO byte lane to a BAR_W-bit bar height.
    function automatic logic [BAR_W-1:0] lane_height(input logic [7:0] lane);
`ifdef BAR_SATURATE_EN
        if (int'(lane) > MAX_H)
            return BAR_W'(MAX_H);
        return lane[BAR_W-1:0];
`else
        return lane[BAR_W-1:0];
`endif
    endfunction

    assign words_left = (issue_cnt < CNT_W'(WORDS));
    // NOTE: rdreq is combinational so the FIFO sees it in the same cycle
    // fifo_empty drops; registering it would overread by one word.
    assign bus.fifo_rdreq = (state == S_LOAD) && !bus.fifo_empty && words_left;
    assign bus.busy       = (state != S_IDLE);
    assign tmo_hit   = (state == S_LOAD) && bus.fifo_empty && words_left &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign last_capt = rd_d1 && (capt_cnt == CNT_W'(WORDS - 1));

    // Convert the four byte lanes of the word returned by the FIFO.
    always_comb begin
        // NOTE: default assignment first so no path leaves bits unassigned
        // (which would infer a latch).
        word_heights = '0;
        for (int j = 0; j < 4; j++)
            word_heights[j*BAR_W +: BAR_W] = lane_height(bus.fifo_q[8*j +: 8]);
    end

    // Capture each returned word into its slot of the shadow buffer.
    // NOTE: the shadow is a plain data store without reset; it only reaches
    // height_out after a complete load has overwritten every slot.
    always_ff @(posedge clk) begin
        if (rd_d1) begin
            for (int k = 0; k < WORDS; k++)
                if (capt_cnt == CNT_W'(k))
                    shadow[k*WORD_H_W +: WORD_H_W] <= word_heights;
        end
    end

    // Control FSM, counters, pending request, display register and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            issue_cnt     <= '0;
            capt_cnt      <= '0;
            tmo_cnt       <= '0;
            rd_d1         <= 1'b0;
            pending_start <= 1'b0;
            bus.height_out    <= '0;
            bus.frame_valid   <= 1'b0;
            bus.underflow_err <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            rd_d1           <= bus.fifo_rdreq;

            // One-deep request queue while a load or swap is in progress.
            if (bus.start && bus.busy && !pending_start)
                pending_start <= 1'b1;

            case (state)
                S_IDLE: begin
                    // start wins over a coincident frame_start here.
                    if (bus.start) begin
                        issue_cnt         <= '0;
                        capt_cnt          <= '0;
                        tmo_cnt           <= '0;
                        bus.underflow_err <= 1'b0;
                        state             <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.fifo_rdreq) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        tmo_cnt   <= '0;
                    end else if (bus.fifo_empty && words_left) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (rd_d1)
                        capt_cnt <= capt_cnt + 1'b1;
                    if (tmo_hit) begin
                        // Abort: partial shadow is abandoned, and a queued
                        // request is dropped along with it.
                        state             <= S_IDLE;
                        bus.underflow_err <= 1'b1;
                        pending_start     <= 1'b0;
                    end else if (last_capt) begin
                        state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (bus.frame_start) begin
                        bus.height_out  <= shadow;
                        bus.frame_valid <= 1'b1;
                        if (pending_start || bus.start) begin
                            issue_cnt     <= '0;
                            capt_cnt      <= '0;
                            tmo_cnt       <= '0;
                            pending_start <= 1'b0;
                            state         <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bar_frame_loader.sv
// Directed self-checking bench for bar_frame_loader with a behavioural
// non-show-ahead FIFO model. Expected heights are built from the stimulus.
module tb_bar_frame_loader;
    localparam int NUM_BARS = 20;
    localparam int BAR_W    = 6;
    localparam int H_W      = NUM_BARS * BAR_W;

    logic clk;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   rd_count     = 0;
    int   fv_count     = 0;
    logic [31:0] fifo_mem[$];
    logic [H_W-1:0] exp_a, exp_b, exp_sat;

    bar_frame_loader_if #(.NUM_BARS(NUM_BARS), .BAR_W(BAR_W)) bus ();

    bar_frame_loader #(.NUM_BARS(NUM_BARS), .BAR_W(BAR_W), .TIMEOUT_CYC(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Four lanes base..base+3, lane 0 in the low byte.
    function automatic logic [31:0] make_word(input int base);
        return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
    endfunction

    task automatic push(input logic [31:0] w);
        fifo_mem.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // Advance one clock; called and returns at 1 time unit after a rising edge.
    task automatic tick();
        logic rd;
        #4;
        rd = bus.fifo_rdreq;
        if (rd) rd_count++;
        @(posedge clk);
        #1;
        if (rd && fifo_mem.size() > 0) bus.fifo_q = fifo_mem.pop_front();
        bus.fifo_empty = (fifo_mem.size() == 0);
        if (bus.frame_valid) fv_count++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fv0;
        for (int i = 0; i < NUM_BARS; i++) begin
            exp_a[i*BAR_W +: BAR_W] = BAR_W'(i);
            exp_b[i*BAR_W +: BAR_W] = BAR_W'(20 + i);
        end
        exp_sat = '0;
`ifdef BAR_SATURATE_EN
        exp_sat[4*BAR_W-1:0] = {6'd0, 6'd63, 6'd63, 6'd63};
`else
        exp_sat[4*BAR_W-1:0] = {6'd0, 6'd63, 6'd0, 6'd63};
`endif

        reset = 1'b1;
        bus.start = 1'b0;
        bus.frame_start = 1'b0;
        bus.fifo_q = '0;
        bus.fifo_empty = 1'b1;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_height", 128'(bus.height_out), 128'(0));
        check("rst_fvalid", 128'(bus.frame_valid), 128'(0));
        check("rst_busy",   128'(bus.busy), 128'(0));
        check("rst_uflow",  128'(bus.underflow_err), 128'(0));
        check("rst_rdreq",  128'(bus.fifo_rdreq), 128'(0));

        // Basic load: bars 0..19
        for (int k = 0; k < 5; k++) push(make_word(4 * k));
        rd_count = 0; fv_count = 0;
        pulse_start();                          // edge 0
        check("basic_rdreq_c1", 128'(bus.fifo_rdreq), 128'(1));
        ticks(5);                               // edges 1..5
        check("basic_rdreq_off", 128'(bus.fifo_rdreq), 128'(0));
        check("basic_rd_count",  128'(rd_count), 128'(5));
        ticks(14);                              // edges 6..19
        check("basic_no_early", 128'(bus.height_out), 128'(0));
        pulse_frame();                          // edge 20
        check("basic_height", 128'(bus.height_out), 128'(exp_a));
        check("basic_fvalid", 128'(bus.frame_valid), 128'(1));
        check("basic_idle",   128'(bus.busy), 128'(0));
        tick();
        check("basic_fv_once", 128'(fv_count), 128'(1));
        check("basic_rd_total", 128'(rd_count), 128'(5));

        // No tearing: frame held back for 500 cycles
        for (int k = 0; k < 5; k++) push(make_word(20 + 4 * k));
        pulse_start();
        ticks(510);
        check("hold_height", 128'(bus.height_out), 128'(exp_a));
        check("hold_busy",   128'(bus.busy), 128'(1));
        check("hold_fv",     128'(fv_count), 128'(1));
        pulse_frame();
        check("hold_swap",   128'(bus.height_out), 128'(exp_b));
        check("hold_fvalid", 128'(bus.frame_valid), 128'(1));

        // Underflow: only 3 of 5 words present
        tick();
        for (int k = 0; k < 3; k++) push(make_word(4 * k));
        rd_count = 0;
        pulse_start();                          // edge 0
        n = 0;
        while (bus.busy && n < 1100) begin
            tick();
            n++;
        end
        check("uflow_cycles", 128'(n), 128'(1027));
        check("uflow_rd",     128'(rd_count), 128'(3));
        check("uflow_err",    128'(bus.underflow_err), 128'(1));
        check("uflow_height", 128'(bus.height_out), 128'(exp_b));
        pulse_frame();
        check("uflow_no_swap", 128'(bus.height_out), 128'(exp_b));
        check("uflow_no_fv",   128'(bus.frame_valid), 128'(0));
        check("uflow_sticky",  128'(bus.underflow_err), 128'(1));
        for (int k = 0; k < 5; k++) push(make_word(4 * k));
        pulse_start();
        check("uflow_clear", 128'(bus.underflow_err), 128'(0));
        ticks(10);
        pulse_frame();
        check("uflow_reload", 128'(bus.height_out), 128'(exp_a));

        // Back-to-back: second start in LOAD, third in PENDING (dropped)
        tick();
        for (int k = 0; k < 5; k++) push(make_word(20 + 4 * k));
        for (int k = 0; k < 5; k++) push(make_word(4 * k));
        rd_count = 0;
        fv0 = fv_count;
        pulse_start();                          // edge 0
        ticks(2);
        pulse_start();                          // edge 3, during LOAD
        ticks(4);                               // PENDING from edge 6
        pulse_start();                          // edge 8, during PENDING
        tick();
        pulse_frame();                          // first swap
        check("b2b_first",  128'(bus.height_out), 128'(exp_b));
        check("b2b_busy",   128'(bus.busy), 128'(1));
        check("b2b_rdreq",  128'(bus.fifo_rdreq), 128'(1));
        check("b2b_rd_mid", 128'(rd_count), 128'(5));
        ticks(10);
        pulse_frame();                          // second swap
        check("b2b_second", 128'(bus.height_out), 128'(exp_a));
        ticks(3);
        check("b2b_idle",   128'(bus.busy), 128'(0));
        check("b2b_rd_all", 128'(rd_count), 128'(10));
        check("b2b_frames", 128'(fv_count - fv0), 128'(2));

        // Saturation / truncation of out-of-range lanes
        push(32'h003F_40FF);
        for (int k = 0; k < 4; k++) push(32'h0);
        pulse_start();
        ticks(10);
        pulse_frame();
        check("sat_height", 128'(bus.height_out), 128'(exp_sat));

        // Reset in the middle of a load
        tick();
        for (int k = 0; k < 5; k++) push(make_word(4 * k));
        pulse_start();                          // edge 0
        ticks(2);                               // two rdreqs accepted
        reset = 1'b1;
        tick();
        check("mrst_rdreq",  128'(bus.fifo_rdreq), 128'(0));
        check("mrst_busy",   128'(bus.busy), 128'(0));
        check("mrst_height", 128'(bus.height_out), 128'(0));
        check("mrst_uflow",  128'(bus.underflow_err), 128'(0));
        reset = 1'b0;
        tick();
        check("mrst_stay_idle", 128'(bus.busy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
